mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and single-port memory bus shared by mem_arbiter and its environment.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_wen;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_wen, mem_ren, mem_waddr, mem_raddr, mem_wdata, conflict_cnt
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_wen, mem_ren, mem_waddr, mem_raddr, mem_wdata, conflict_cnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter in front of a single-port memory with
// one-cycle read latency; routes read data back to the owner and counts conflicts.
module mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } port_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_I    = 2'd1,
    RSP_D    = 2'd2
  } rsp_own_e;

  port_e             last_gnt_q, last_gnt_d;
  rsp_own_e          rsp_own_q, rsp_own_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic              conflict;
  logic              i_win;
  logic              d_win;
  logic              mem_wen;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Grants are forced low while reset is asserted, independent of the clock.
  always_comb begin
    conflict = bus.i_req & bus.d_req;
    i_win    = 1'b0;
    d_win    = 1'b0;
    if (!rst) begin
      if (conflict) begin
        i_win = (last_gnt_q == GNT_D);
        d_win = (last_gnt_q == GNT_I);
      end else begin
        i_win = bus.i_req;
        d_win = bus.d_req;
      end
    end
  end

  always_comb begin
    last_gnt_d     = last_gnt_q;
    rsp_own_d      = RSP_NONE;
    conflict_cnt_d = conflict_cnt_q;
    mem_wen        = 1'b0;
    mem_ren        = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    if (i_win) begin
      mem_ren    = 1'b1;
      mem_addr   = bus.i_addr;
      last_gnt_d = GNT_I;
      rsp_own_d  = RSP_I;
    end else if (d_win) begin
      mem_addr   = bus.d_addr;
      last_gnt_d = GNT_D;
      if (bus.d_we) begin
        mem_wen   = 1'b1;
        mem_wdata = bus.d_wdata;
      end else begin
        mem_ren   = 1'b1;
        rsp_own_d = RSP_D;
      end
    end

    if (conflict && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Reset leaves last_gnt at D so the first conflict goes to fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q     <= GNT_D;
      rsp_own_q      <= RSP_NONE;
      conflict_cnt_q <= '0;
    end else begin
      last_gnt_q     <= last_gnt_d;
      rsp_own_q      <= rsp_own_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.i_gnt        = i_win;
  assign bus.d_gnt        = d_win;
  assign bus.mem_wen      = mem_wen;
  assign bus.mem_ren      = mem_ren;
  assign bus.mem_waddr    = mem_addr;
  assign bus.mem_raddr    = mem_addr;
  assign bus.mem_wdata    = mem_wdata;

  assign bus.i_rvalid     = (rsp_own_q == RSP_I);
  assign bus.d_rvalid     = (rsp_own_q == RSP_D);
  assign bus.i_rdata      = (rsp_own_q == RSP_I) ? bus.mem_rdata : '0;
  assign bus.d_rdata      = (rsp_own_q == RSP_D) ? bus.mem_rdata : '0;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule
